// File: rtl/des_block_serializer.sv
// Buffers 64-bit DES result blocks and serializes them, low word first, as
// 16-bit words for the PipeOut endpoint handshake.
module des_block_serializer #(
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk1,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  blk_valid,
    input  logic [63:0]           blk_data,
    output logic                  blk_ready,
    input  logic                  pipe_read,
    output logic [15:0]           pipe_data,
    output logic                  pipe_ready,
    output logic [DEPTH_LOG2+2:0] word_count,
    output logic                  overflow,
    output logic                  underflow
);
    // state | meaning
    // W0    | next word out is bits 15:0 of the head block
    // W1    | next word out is bits 31:16
    // W2    | next word out is bits 47:32
    // W3    | next word out is bits 63:48; reading it frees the block slot

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2+2:0] WC_BLK   = (DEPTH_LOG2 + 3)'(4);
    localparam logic [DEPTH_LOG2+2:0] WC_ONE   = (DEPTH_LOG2 + 3)'(1);

    typedef enum logic [1:0] {
        W0 = 2'd0,
        W1 = 2'd1,
        W2 = 2'd2,
        W3 = 2'd3
    } ser_state_t;

    ser_state_t state_q, state_d;

    logic [63:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [DEPTH_LOG2:0]   blk_cnt;
    logic [DEPTH_LOG2+2:0] wc_q, wc_d;
    logic                  wr_en, rd_en, blk_done;
    logic [5:0]            bit_lo;

    assign pipe_ready = (blk_cnt != '0);
    assign blk_ready  = (blk_cnt < CNT_FULL);
    assign wr_en      = blk_valid & blk_ready;
    assign rd_en      = pipe_read & pipe_ready;
    assign word_count = wc_q;
    assign bit_lo     = {state_q, 4'b0000};

    always_comb begin
        state_d  = state_q;
        blk_done = 1'b0;
        if (rd_en) begin
            case (state_q)
                W0: state_d = W1;
                W1: state_d = W2;
                W2: state_d = W3;
                W3: begin
                    state_d  = W0;
                    blk_done = 1'b1;
                end
                default: state_d = W0;
            endcase
        end
    end

    always_comb begin
        pipe_data = 16'h0000;
        if (pipe_ready)
            pipe_data = mem[rd_ptr][bit_lo +: 16];
    end

    always_comb begin
        wc_d = wc_q;
        if (wr_en)
            wc_d = wc_d + WC_BLK;
        if (rd_en)
            wc_d = wc_d - WC_ONE;
    end

    // Storage carries no reset; stale slots are never visible past blk_cnt.
    always_ff @(posedge clk1) begin
        if (!reset && !flush && wr_en)
            mem[wr_ptr] <= blk_data;
    end

    always_ff @(posedge clk1) begin
        if (reset || flush) begin
            state_q   <= W0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            blk_cnt   <= '0;
            wc_q      <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            state_q <= state_d;
            wc_q    <= wc_d;
            if (wr_en)
                wr_ptr <= wr_ptr + 1'b1;
            if (blk_done)
                rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, blk_done})
                2'b10:   blk_cnt <= blk_cnt + CNT_ONE;
                2'b01:   blk_cnt <= blk_cnt - CNT_ONE;
                default: blk_cnt <= blk_cnt;
            endcase
            if (blk_valid && !blk_ready)
                overflow <= 1'b1;
            if (pipe_read && !pipe_ready)
                underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_des_block_serializer.sv
// Directed bench for des_block_serializer: a vector table for the basic
// sequences plus hand-written fill, wrap and same-cycle event sequences.
module tb_des_block_serializer;

    logic        clk1 = 1'b0;
    logic        reset, flush, blk_valid, pipe_read;
    logic [63:0] blk_data;
    logic        blk_ready, pipe_ready, overflow, underflow;
    logic [15:0] pipe_data;
    logic [5:0]  word_count;

    int n_checks = 0;
    int n_fail   = 0;

    des_block_serializer #(.DEPTH_LOG2(3)) dut (
        .clk1       (clk1),
        .reset      (reset),
        .flush      (flush),
        .blk_valid  (blk_valid),
        .blk_data   (blk_data),
        .blk_ready  (blk_ready),
        .pipe_read  (pipe_read),
        .pipe_data  (pipe_data),
        .pipe_ready (pipe_ready),
        .word_count (word_count),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    always #5 clk1 = ~clk1;

    typedef struct {
        logic        r, f, v;
        logic [63:0] d;
        logic        rd;
        logic        e_br, e_pr;
        logic [15:0] e_pd;
        int          e_wc;
        logic        e_ov, e_un;
    } vec_t;

    vec_t vecs[16];

    function automatic logic [15:0] wd(input int b, input int w);
        return 16'h5A00 | 16'(b * 16 + w);
    endfunction

    function automatic logic [63:0] mkblk(input int b);
        return {wd(b, 3), wd(b, 2), wd(b, 1), wd(b, 0)};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic f, input logic v,
                        input logic [63:0] d, input logic rd);
        reset = r; flush = f; blk_valid = v; blk_data = d; pipe_read = rd;
        @(posedge clk1);
        #1;
        reset = 1'b0; flush = 1'b0; blk_valid = 1'b0; pipe_read = 1'b0;
        blk_data = '0;
    endtask

    initial begin
        logic [15:0] exp_q[$];
        logic [15:0] w;
        logic [63:0] blk_a, blk_b, blk_c;

        reset = 1'b1; flush = 1'b0; blk_valid = 1'b0; pipe_read = 1'b0; blk_data = '0;

        blk_a = 64'hAAAA_BBBB_CCCC_DDDD;
        blk_b = 64'h1234_5678_9ABC_DEF0;
        blk_c = 64'h0F0F_1E1E_2D2D_3C3C;
        //               r  f  v  data                    rd  br pr pd        wc ov un
        vecs[0]  = '{1, 0, 0, 64'h0,                     0,  1, 0, 16'h0000, 0, 0, 0};
        vecs[1]  = '{0, 0, 1, 64'h4444_3333_2222_1111,   0,  1, 1, 16'h1111, 4, 0, 0};
        vecs[2]  = '{0, 0, 0, 64'h0,                     1,  1, 1, 16'h2222, 3, 0, 0};
        vecs[3]  = '{0, 0, 0, 64'h0,                     1,  1, 1, 16'h3333, 2, 0, 0};
        vecs[4]  = '{0, 0, 0, 64'h0,                     1,  1, 1, 16'h4444, 1, 0, 0};
        vecs[5]  = '{0, 0, 0, 64'h0,                     1,  1, 0, 16'h0000, 0, 0, 0};
        vecs[6]  = '{0, 0, 0, 64'h0,                     1,  1, 0, 16'h0000, 0, 0, 1};
        vecs[7]  = '{0, 1, 0, 64'h0,                     0,  1, 0, 16'h0000, 0, 0, 0};
        vecs[8]  = '{0, 0, 1, blk_a,                     0,  1, 1, 16'hDDDD, 4, 0, 0};
        vecs[9]  = '{0, 0, 1, blk_b,                     0,  1, 1, 16'hDDDD, 8, 0, 0};
        vecs[10] = '{0, 0, 0, 64'h0,                     1,  1, 1, 16'hCCCC, 7, 0, 0};
        vecs[11] = '{0, 0, 0, 64'h0,                     1,  1, 1, 16'hBBBB, 6, 0, 0};
        vecs[12] = '{1, 0, 0, 64'h0,                     0,  1, 0, 16'h0000, 0, 0, 0};
        vecs[13] = '{0, 0, 1, blk_c,                     0,  1, 1, 16'h3C3C, 4, 0, 0};
        vecs[14] = '{0, 0, 0, 64'h0,                     1,  1, 1, 16'h2D2D, 3, 0, 0};
        vecs[15] = '{0, 1, 1, 64'hFFFF_FFFF_FFFF_FFFF,   1,  1, 0, 16'h0000, 0, 0, 0};

        for (int i = 0; i < 16; i++) begin
            step(vecs[i].r, vecs[i].f, vecs[i].v, vecs[i].d, vecs[i].rd);
            chk($sformatf("vec%0d blk_ready", i),  64'(blk_ready),  64'(vecs[i].e_br));
            chk($sformatf("vec%0d pipe_ready", i), 64'(pipe_ready), 64'(vecs[i].e_pr));
            chk($sformatf("vec%0d pipe_data", i),  64'(pipe_data),  64'(vecs[i].e_pd));
            chk($sformatf("vec%0d word_count", i), 64'(word_count), 64'(vecs[i].e_wc));
            chk($sformatf("vec%0d overflow", i),   64'(overflow),   64'(vecs[i].e_ov));
            chk($sformatf("vec%0d underflow", i),  64'(underflow),  64'(vecs[i].e_un));
        end

        // Fill to capacity, attempt a ninth block, then drain everything.
        for (int b = 0; b < 8; b++) begin
            step(0, 0, 1, mkblk(b), 0);
            chk("fill word_count", 64'(word_count), 64'(4 * (b + 1)));
        end
        chk("fill blk_ready", 64'(blk_ready), 64'(0));
        step(0, 0, 1, 64'hDEAD_BEEF_CAFE_F00D, 0);
        chk("fill9 overflow", 64'(overflow), 64'(1));
        chk("fill9 word_count", 64'(word_count), 64'(32));
        for (int b = 0; b < 8; b++)
            for (int k = 0; k < 4; k++) begin
                chk("fill drain data", 64'(pipe_data), 64'(wd(b, k)));
                step(0, 0, 0, '0, 1);
            end
        chk("fill drained pipe_ready", 64'(pipe_ready), 64'(0));
        chk("fill overflow sticky", 64'(overflow), 64'(1));
        step(0, 1, 0, '0, 0);

        // 20 blocks, two written ahead, refilled while reading; pointers wrap twice.
        for (int b = 0; b < 2; b++) begin
            step(0, 0, 1, mkblk(20 + b), 0);
            for (int k = 0; k < 4; k++) exp_q.push_back(wd(20 + b, k));
        end
        for (int i = 0; i < 20; i++)
            for (int k = 0; k < 4; k++) begin
                w = exp_q.pop_front();
                chk("wrap data", 64'(pipe_data), 64'(w));
                if (k == 0 && i + 2 < 20) begin
                    step(0, 0, 1, mkblk(22 + i), 1);
                    for (int j = 0; j < 4; j++) exp_q.push_back(wd(22 + i, j));
                end else begin
                    step(0, 0, 0, '0, 1);
                end
            end
        chk("wrap word_count", 64'(word_count), 64'(0));
        chk("wrap overflow", 64'(overflow), 64'(0));
        chk("wrap underflow", 64'(underflow), 64'(0));

        // Write and W3 read in the same cycle with one block held.
        step(0, 0, 1, mkblk(100), 0);
        for (int k = 0; k < 3; k++) step(0, 0, 0, '0, 1);
        chk("simul pre data", 64'(pipe_data), 64'(wd(100, 3)));
        step(0, 0, 1, mkblk(101), 1);
        chk("simul data", 64'(pipe_data), 64'(wd(101, 0)));
        chk("simul word_count", 64'(word_count), 64'(4));
        chk("simul overflow", 64'(overflow), 64'(0));
        for (int k = 0; k < 4; k++) begin
            chk("simul drain", 64'(pipe_data), 64'(wd(101, k)));
            step(0, 0, 0, '0, 1);
        end
        chk("simul empty", 64'(pipe_ready), 64'(0));

        // Same event with the buffer full: the write is dropped.
        for (int b = 0; b < 8; b++) step(0, 0, 1, mkblk(b), 0);
        for (int k = 0; k < 3; k++) step(0, 0, 0, '0, 1);
        step(0, 0, 1, 64'hDEAD_BEEF_CAFE_F00D, 1);
        chk("full simul overflow", 64'(overflow), 64'(1));
        chk("full simul word_count", 64'(word_count), 64'(28));
        chk("full simul blk_ready", 64'(blk_ready), 64'(1));
        for (int b = 1; b < 8; b++)
            for (int k = 0; k < 4; k++) begin
                chk("full simul drain", 64'(pipe_data), 64'(wd(b, k)));
                step(0, 0, 0, '0, 1);
            end
        chk("full simul empty", 64'(pipe_ready), 64'(0));
        chk("full simul pipe_data", 64'(pipe_data), 64'(0));

        // Reset outranks flush and a concurrent write.
        step(1, 1, 1, mkblk(5), 0);
        chk("reset prio word_count", 64'(word_count), 64'(0));
        chk("reset prio overflow", 64'(overflow), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
